// File: rtl/semaforo_pkg.sv
// Shared definitions for the two-road intersection phase scheduler:
// phase encoding, default timing and the lamp decode.
package semaforo_pkg;

   localparam logic [2:0] F_VERDE_A = 3'd0;
   localparam logic [2:0] F_AMAR_A  = 3'd1;
   localparam logic [2:0] F_ROJO_A  = 3'd2;
   localparam logic [2:0] F_VERDE_B = 3'd3;
   localparam logic [2:0] F_AMAR_B  = 3'd4;
   localparam logic [2:0] F_ROJO_B  = 3'd5;
   localparam logic [2:0] F_PEATON  = 3'd6;

   typedef enum logic [2:0] {
      VERDE_A = F_VERDE_A,
      AMAR_A  = F_AMAR_A,
      ROJO_A  = F_ROJO_A,
      VERDE_B = F_VERDE_B,
      AMAR_B  = F_AMAR_B,
      ROJO_B  = F_ROJO_B,
      PEATON  = F_PEATON
   } fase_t;

   localparam int unsigned CW_DEF          = 4;
   localparam int unsigned T_VERDE_MIN_DEF = 8;
   localparam int unsigned T_AMARILLO_DEF  = 3;
   localparam int unsigned T_TODOROJO_DEF  = 2;
   localparam int unsigned T_PEATON_DEF    = 6;

   typedef struct packed {
      logic verde_a;
      logic amarillo_a;
      logic rojo_a;
      logic verde_b;
      logic amarillo_b;
      logic rojo_b;
      logic paso;
   } lamparas_t;

   // Moore lamp decode: exactly one lamp per road in every phase.
   function automatic lamparas_t decodifica(input fase_t f);
      lamparas_t l;
      l = '0;
      case (f)
         VERDE_A: begin l.verde_a    = 1'b1; l.rojo_b = 1'b1; end
         AMAR_A:  begin l.amarillo_a = 1'b1; l.rojo_b = 1'b1; end
         VERDE_B: begin l.verde_b    = 1'b1; l.rojo_a = 1'b1; end
         AMAR_B:  begin l.amarillo_b = 1'b1; l.rojo_a = 1'b1; end
         PEATON:  begin l.rojo_a = 1'b1; l.rojo_b = 1'b1; l.paso = 1'b1; end
         default: begin l.rojo_a = 1'b1; l.rojo_b = 1'b1; end
      endcase
      return l;
   endfunction

endpackage

// File: rtl/semaforo_arbitro_contador.sv
// Loadable phase down-counter; saturates at zero and flags it with cero.
module contador_fase #(
   parameter int unsigned CW      = 4,
   parameter int unsigned RST_VAL = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          load,
   input  logic [CW-1:0] valor,
   output logic [CW-1:0] cuenta,
   output logic          cero
);

   logic [CW-1:0] cuenta_sig;

   always_comb begin
      cuenta_sig = cuenta;
      if (en) begin
         if (load)
            cuenta_sig = valor;
         else if (cuenta != '0)
            cuenta_sig = cuenta - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cuenta <= CW'(RST_VAL);
         cero   <= (RST_VAL == 0);
      end else begin
         cuenta <= cuenta_sig;
         cero   <= (cuenta_sig == '0);
      end
   end

endmodule

// File: rtl/semaforo_arbitro.sv
// Two-road intersection phase scheduler with pedestrian walk phase,
// demand latching, rest-in-green and registered lamp outputs.
module semaforo_arbitro
   import semaforo_pkg::*;
#(
   parameter int unsigned CW          = CW_DEF,
   parameter int unsigned T_VERDE_MIN = T_VERDE_MIN_DEF,
   parameter int unsigned T_AMARILLO  = T_AMARILLO_DEF,
   parameter int unsigned T_TODOROJO  = T_TODOROJO_DEF,
   parameter int unsigned T_PEATON    = T_PEATON_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enable,
   input  logic          SensorA,
   input  logic          SensorB,
   input  logic          PasoA,
   input  logic          PasoB,
   output logic          VerdeA,
   output logic          AmarilloA,
   output logic          RojoA,
   output logic          VerdeB,
   output logic          AmarilloB,
   output logic          RojoB,
   output logic          paso_peaton,
   output logic [CW-1:0] cuenta,
   output logic [2:0]    fase
);

   localparam int unsigned T_MAX = 32'd1 << CW;
   localparam logic        ULT_A = 1'b0;
   localparam logic        ULT_B = 1'b1;

   // Every phase length must be loadable as T-1 into the CW-bit counter.
   if (T_VERDE_MIN < 1 || T_VERDE_MIN > T_MAX) begin : g_err_verde
      $error("T_VERDE_MIN out of range for CW");
   end
   if (T_AMARILLO < 1 || T_AMARILLO > T_MAX) begin : g_err_amarillo
      $error("T_AMARILLO out of range for CW");
   end
   if (T_TODOROJO < 1 || T_TODOROJO > T_MAX) begin : g_err_todorojo
      $error("T_TODOROJO out of range for CW");
   end
   if (T_PEATON < 1 || T_PEATON > T_MAX) begin : g_err_peaton
      $error("T_PEATON out of range for CW");
   end

   fase_t         estado;
   fase_t         estado_sig;
   logic          dem_a;
   logic          dem_b;
   logic          dem_p;
   logic          ultimo;
   logic          cero;
   logic          carga;
   logic [CW-1:0] valor;
   lamparas_t     lamp;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         estado <= VERDE_A;
      else
         estado <= estado_sig;
   end

   // Next phase; only evaluated once the running phase has expired.
   always_comb begin
      estado_sig = estado;
      if (enable && cero) begin
         case (estado)
            VERDE_A: if (dem_b || dem_p) estado_sig = AMAR_A;
            AMAR_A:  estado_sig = ROJO_A;
            ROJO_A:  estado_sig = dem_p ? PEATON : VERDE_B;
            VERDE_B: if (dem_a || dem_p) estado_sig = AMAR_B;
            AMAR_B:  estado_sig = ROJO_B;
            ROJO_B:  estado_sig = dem_p ? PEATON : VERDE_A;
            PEATON: begin
               if (ultimo == ULT_A)
                  estado_sig = dem_b ? VERDE_B : VERDE_A;
               else
                  estado_sig = dem_a ? VERDE_A : VERDE_B;
            end
            default: estado_sig = VERDE_A;
         endcase
      end
   end

   // Every transition changes phase, so a phase change is the reload trigger.
   assign carga = (estado_sig != estado);

   always_comb begin
      valor = CW'(T_VERDE_MIN - 1);
      case (estado_sig)
         AMAR_A, AMAR_B: valor = CW'(T_AMARILLO - 1);
         ROJO_A, ROJO_B: valor = CW'(T_TODOROJO - 1);
         PEATON:         valor = CW'(T_PEATON - 1);
         default:        valor = CW'(T_VERDE_MIN - 1);
      endcase
   end

   contador_fase #(
      .CW      (CW),
      .RST_VAL (T_VERDE_MIN - 1)
   ) u_contador (
      .clk    (clk),
      .rst    (rst),
      .en     (enable),
      .load   (carga),
      .valor  (valor),
      .cuenta (cuenta),
      .cero   (cero)
   );

   // Demand latches keep capturing while frozen; entering the serving phase wins over a new request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dem_a  <= 1'b0;
         dem_b  <= 1'b0;
         dem_p  <= 1'b0;
         ultimo <= ULT_A;
         lamp   <= decodifica(VERDE_A);
      end else begin
         if (estado_sig == VERDE_A && estado != VERDE_A)
            dem_a <= 1'b0;
         else if (SensorA && estado != VERDE_A)
            dem_a <= 1'b1;

         if (estado_sig == VERDE_B && estado != VERDE_B)
            dem_b <= 1'b0;
         else if (SensorB && estado != VERDE_B)
            dem_b <= 1'b1;

         if (estado_sig == PEATON && estado != PEATON)
            dem_p <= 1'b0;
         else if ((PasoA || PasoB) && estado != PEATON)
            dem_p <= 1'b1;

         if (estado == AMAR_A && estado_sig == ROJO_A)
            ultimo <= ULT_A;
         else if (estado == AMAR_B && estado_sig == ROJO_B)
            ultimo <= ULT_B;

         lamp <= decodifica(estado_sig);
      end
   end

   assign fase        = estado;
   assign VerdeA      = lamp.verde_a;
   assign AmarilloA   = lamp.amarillo_a;
   assign RojoA       = lamp.rojo_a;
   assign VerdeB      = lamp.verde_b;
   assign AmarilloB   = lamp.amarillo_b;
   assign RojoB       = lamp.rojo_b;
   assign paso_peaton = lamp.paso;

endmodule

// File: doc/semaforo_arbitro.md
Name: semaforo_arbitro

Overview:
Phase scheduler for a two-road intersection: road A, road B, and a shared pedestrian phase.
- Latches vehicle and pedestrian demand.
- Alternates green between roads with minimum-green, yellow and all-red clearance intervals.
- Inserts an all-vehicle-red walk phase on pedestrian demand.
- Drives the lamp outputs and a per-phase countdown for the display path.

Parameters:
CW, 4, width of cuenta and the internal phase counter
T_VERDE_MIN, 8, minimum green length in cycles
T_AMARILLO, 3, yellow length in cycles
T_TODOROJO, 2, all-red clearance length in cycles
T_PEATON, 6, pedestrian walk length in cycles

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
enable  in  1  advances phase timing when high
SensorA  in  1  vehicle demand, road A (level or pulse)
SensorB  in  1  vehicle demand, road B
PasoA  in  1  pedestrian button, crossing A
PasoB  in  1  pedestrian button, crossing B
VerdeA, AmarilloA, RojoA  out  1 each  road A lamps
VerdeB, AmarilloB, RojoB  out  1 each  road B lamps
paso_peaton  out  1  walk indication
cuenta  out  CW  remaining cycles in the current phase
fase  out  3  current state encoding

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high. All state is registered.
- Reset values:
  - State VERDE_A, cuenta = T_VERDE_MIN-1.
  - VerdeA=1, RojoB=1, all other lamps 0, paso_peaton=0.
  - Demand latches dem_a, dem_b, dem_p = 0; ultimo (last-green road) = A.
- States: VERDE_A, AMAR_A, ROJO_A, VERDE_B, AMAR_B, ROJO_B, PEATON.
- Lamp decode (Moore, from state only):
  - VERDE_x: Verde for road x, Rojo for the other road.
  - AMAR_x: Amarillo for road x, Rojo for the other road.
  - ROJO_x and PEATON: both Rojo.
  - paso_peaton=1 only in PEATON.
  - Exactly one lamp per road is lit in every state.
- Phase entry: cuenta loads T-1 for the new phase, so each phase lasts exactly T enabled cycles.
- Counting:
  - cuenta decrements on each enabled edge while >0.
  - In VERDE_x, cuenta holds at 0 until demand exists (rest-in-green).
- Transitions, evaluated only when enable=1 and cuenta==0:
  - VERDE_A -> AMAR_A if dem_b|dem_p.
  - AMAR_A -> ROJO_A; on this transition ultimo <= A.
  - ROJO_A -> PEATON if dem_p, else VERDE_B.
  - VERDE_B, AMAR_B and ROJO_B behave symmetrically, with ultimo <= B and ROJO_B -> PEATON if dem_p, else VERDE_A.
  - PEATON -> green of the road opposite ultimo if that road's demand latch is set, else back to the green of ultimo.
- Demand latches:
  - dem_b is set by SensorB in any state except VERDE_B.
  - dem_a is set by SensorA in any state except VERDE_A.
  - dem_p is set by PasoA|PasoB in any state except PEATON.
  - Each latch clears on the edge that enters its serving phase. If set and clear coincide, clear wins (the request is served by the phase being entered).
- enable=0:
  - State, cuenta and ultimo are frozen; outputs are held.
  - Demand latches still capture requests.
- rst mid-operation: immediate (asynchronous) return to reset values, from any state including PEATON and yellow.
- Width rule: every T_* must be in 1..2^CW, enforced by an elaboration-time check. cuenta never underflows.

Decomposition:
- Package semaforo_pkg holds:
  - fase state encoding localparams, 3 bits: VERDE_A=0, AMAR_A=1, ROJO_A=2, VERDE_B=3, AMAR_B=4, ROJO_B=5, PEATON=6.
  - default timing constants.
- Sub-module contador_fase: loadable down-counter with inputs clk, rst, en, load, valor[CW-1:0] and outputs cuenta and cero. It saturates at 0.
- The FSM, demand latches and lamp decode stay in semaforo_arbitro.

Test Plan:
Cycle 0 is the state after rst deasserts; cycle n is after the n-th rising edge. Defaults apply, enable=1 unless stated.
1. No requests for 30 cycles -> VerdeA=1 throughout; cuenta steps 7..0 by cycle 7, then holds 0.
2. SensorB pulsed for 1 cycle at cycle 2 -> VerdeA cycles 0-7, AmarilloA cycles 8-10, both Rojo cycles 11-12, VerdeB from cycle 13 with cuenta=7; dem_b clears at cycle 13.
3. PasoA pulsed at cycle 3, no vehicle demand -> after ROJO_A, PEATON cycles 13-18 with paso_peaton=1 and both Rojo, then VerdeA from cycle 19.
4. SensorB at cycle 1; enable low for cycles 9-13 (during AMAR_A) -> AmarilloA and cuenta frozen at their cycle-9 value; SensorB pulse during the freeze stays latched; sequence resumes with the remaining yellow count.
5. rst asserted asynchronously mid-VERDE_B, between edges -> outputs go to reset values immediately, without waiting for a clock edge.
6. In VERDE_B at cuenta=0, SensorA and PasoB asserted in the same cycle -> AMAR_B (3 cycles), ROJO_B (2 cycles), PEATON (6 cycles), then VERDE_A.
